multiword_adder: RTL and testbench

Sequential wide adder that computes a W-bit sum A+B+Cin by streaming N-bit chunks, least significant first, through one instance of the team's N-bit prefix adder module `prefix`, one chunk per cycle, with a registered carry between chunks. It sits directly upstream of that adder: it slices the operands, feeds each chunk and carry-in, and collects the chunk sums and carry-outs. This gives datapaths a wide add, e.g. 128-bit, without the area of a W-bit prefix tree. A valid/ready handshake is used on both the input and output sides.

---
 rtl/multiword_adder.sv | 186 ++++++++++++++++++
 tb/tb_multiword_adder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_adder.sv
// multiword_adder: sequential W-bit adder computing A + B + Cin by streaming
// N-bit chunks (least significant first) through a single N-bit prefix adder,
// one chunk per cycle, with the inter-chunk carry held in a register.
//
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   in_valid / in_ready operand handshake (in_ready high only when idle)
//   A, B, Cin           operands, sampled only at acceptance
//   out_valid/out_ready result handshake
//   Sum, Cout, Ovf      W-bit sum, unsigned carry-out, signed overflow
//
// Also contains `prefix`, the N-bit Kogge-Stone adder used for each chunk.

module prefix #(
  parameter int N = 32
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N-1:0] g;
  logic [N-1:0] p;
  logic [N:0]   c;

  always_comb begin
    g = a & b;
    p = a ^ b;
    // In-place Kogge-Stone: walking each level from the top bit down means
    // bit i-d still holds the previous level's value when bit i reads it.
    for (int unsigned d = 1; d < N; d = d * 2) begin
      for (int unsigned j = 0; j < N - d; j++) begin
        g[N-1-j] = g[N-1-j] | (p[N-1-j] & g[N-1-j-d]);
        p[N-1-j] = p[N-1-j] & p[N-1-j-d];
      end
    end
    // g/p now span bits [i:0]; fold in the carry-in.
    c[0] = cin;
    for (int unsigned i = 0; i < N; i++) begin
      c[i+1] = g[i] | (p[i] & cin);
    end
    sum  = (a ^ b) ^ c[N-1:0];
    cout = c[N];
  end

endmodule

module multiword_adder #(
  parameter int N = 32,
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Sum,
  output logic         Cout,
  output logic         Ovf
);

  localparam int K  = W / N;
  localparam int IW = (K > 2) ? $clog2(K) : 1;

  if (((W % N) != 0) || (K < 2)) begin : g_bad_params
    $error("multiword_adder: W must be a multiple of N with W/N >= 2");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;
  logic [IW-1:0]  idx_q, idx_d;

  logic [N-1:0]   a_ch;
  logic [N-1:0]   b_ch;
  logic [N-1:0]   ch_sum;
  logic           ch_cout;

  // Chunk select mux for the current index.
  always_comb begin
    a_ch = '0;
    b_ch = '0;
    for (int unsigned k = 0; k < K; k++) begin
      if (idx_q == IW'(k)) begin
        a_ch = a_q[k*N +: N];
        b_ch = b_q[k*N +: N];
      end
    end
  end

  prefix #(.N(N)) u_prefix (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry_q),
    .sum  (ch_sum),
    .cout (ch_cout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int unsigned k = 0; k < K; k++) begin
          if (idx_q == IW'(k)) begin
            sum_d[k*N +: N] = ch_sum;
          end
        end
        carry_d = ch_cout;
        if (idx_q == IW'(K - 1)) begin
          cout_d  = ch_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) & (ch_sum[N-1] != a_q[W-1]);
          state_d = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      idx_q   <= idx_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
  assign Ovf       = ovf_q;

endmodule

// File: tb/tb_multiword_adder.sv
// Testbench for multiword_adder: directed vector table, backpressure and
// mid-run reset sequences on the 128/32 configuration, then randomized
// traffic on both the 128/32 and 16/8 configurations against an
// arithmetic reference model.

module tb_multiword_adder;

  localparam int W  = 128;
  localparam int N  = 32;
  localparam int WS = 16;
  localparam int NS = 8;
  localparam int NRAND = 2000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] A, B, Sum;
  logic         Cin, Cout, Ovf;

  logic          s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  logic [WS-1:0] s_A, s_B, s_Sum;
  logic          s_Cin, s_Cout, s_Ovf;

  multiword_adder #(.N(N), .W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout), .Ovf(Ovf)
  );

  multiword_adder #(.N(NS), .W(WS)) dut_s (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_ready(s_in_ready),
    .A(s_A), .B(s_B), .Cin(s_Cin),
    .out_valid(s_out_valid), .out_ready(s_out_ready),
    .Sum(s_Sum), .Cout(s_Cout), .Ovf(s_Ovf)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } exp_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t vecs[6];
  exp_t qb[$];
  exp_t qs[$];

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: unsigned sum in W+1 bits; overflow when the true signed sum
  // falls outside the W-bit two's-complement range.
  function automatic exp_t model_big(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    exp_t e;
    logic [W:0] u;
    logic signed [W+1:0] s, mx, mn;
    u  = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    s  = $signed({{2{a[W-1]}}, a}) + $signed({{2{b[W-1]}}, b}) + $signed({{(W+1){1'b0}}, c});
    mx = $signed({3'b000, {(W-1){1'b1}}});
    mn = $signed({3'b111, {(W-1){1'b0}}});
    e.sum  = u[W-1:0];
    e.cout = u[W];
    e.ovf  = (s > mx) || (s < mn);
    return e;
  endfunction

  function automatic exp_t model_small(input logic [WS-1:0] a, input logic [WS-1:0] b, input logic c);
    exp_t e;
    logic [WS:0] u;
    logic signed [WS+1:0] s, mx, mn;
    u  = {1'b0, a} + {1'b0, b} + (WS+1)'(c);
    s  = $signed({{2{a[WS-1]}}, a}) + $signed({{2{b[WS-1]}}, b}) + $signed({{(WS+1){1'b0}}, c});
    mx = $signed({3'b000, {(WS-1){1'b1}}});
    mn = $signed({3'b111, {(WS-1){1'b0}}});
    e.sum  = W'(u[WS-1:0]);
    e.cout = u[WS];
    e.ovf  = (s > mx) || (s < mn);
    return e;
  endfunction

  function automatic logic [W-1:0] rand_op();
    logic [W-1:0] v;
    case ($urandom % 8)
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b1, {(W-1){1'b0}}};
      3:       v = {1'b0, {(W-1){1'b1}}};
      default: v = {$urandom(), $urandom(), $urandom(), $urandom()};
    endcase
    return v;
  endfunction

  function automatic logic [WS-1:0] rand_op_s();
    logic [WS-1:0] v;
    case ($urandom % 8)
      0:       v = '1;
      1:       v = '0;
      2:       v = {1'b1, {(WS-1){1'b0}}};
      3:       v = {1'b0, {(WS-1){1'b1}}};
      default: v = WS'($urandom());
    endcase
    return v;
  endfunction

  // Full transaction on the wide DUT with latency and handshake checks.
  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [W-1:0] es, input logic ec, input logic eo);
    int lat;
    lat = 0;
    while (!in_ready && lat < 50) begin tick(); lat++; end
    check({name, " in_ready"}, W'(in_ready), W'(1));
    A = a; B = b; Cin = c; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    A = ~a; B = ~b; Cin = ~c;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check({name, " latency"}, W'(lat), W'(W / N));
    check({name, " sum"}, Sum, es);
    check({name, " cout"}, W'(Cout), W'(ec));
    check({name, " ovf"}, W'(Ovf), W'(eo));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " post hs valid/ready"}, W'({out_valid, in_ready}), W'(2'b01));
  endtask

  initial begin
    exp_t e;
    logic [W-1:0]  sum0;
    logic          cout0, ovf0;
    logic [W-1:0]  na, nb;
    logic [WS-1:0] sa, sb;
    logic          sc;
    int lat, acc_b, acc_s, done_b, done_s, cyc;

    vecs[0] = '{'1, W'(1), 1'b0, '0, 1'b1, 1'b0};
    vecs[1] = '{128'h0000_0000_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, '0, 1'b1,
                128'h0000_0001_0000_0000_0000_0000_0000_0000, 1'b0, 1'b0};
    vecs[2] = '{{1'b0, {(W-1){1'b1}}}, W'(1), 1'b0, {1'b1, {(W-1){1'b0}}}, 1'b0, 1'b1};
    vecs[3] = '{{1'b1, {(W-1){1'b0}}}, {1'b1, {(W-1){1'b0}}}, 1'b0, '0, 1'b1, 1'b1};
    vecs[4] = '{'1, '1, 1'b1, '1, 1'b1, 1'b0};
    vecs[5] = '{128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                128'h1111_1111_1111_1111_1111_1111_1111_1111, 1'b0,
                128'h2345_6789_ABCD_F001_20FE_DCBA_9876_5432, 1'b0, 1'b0};

    reset = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; Cin = 1'b0;
    s_in_valid = 1'b0; s_out_ready = 1'b0; s_A = '0; s_B = '0; s_Cin = 1'b0;
    tick(); tick();
    check("reset sum", Sum, '0);
    check("reset cout/ovf", W'({Cout, Ovf}), '0);
    check("reset valid/ready", W'({out_valid, in_ready}), W'(2'b01));
    check("reset small ready", W'({s_out_valid, s_in_ready}), W'(2'b01));
    @(negedge clk);
    reset = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
             vecs[i].sum, vecs[i].cout, vecs[i].ovf);
    end

    // Backpressure: hold result in DONE while new operands wait on in_valid.
    A = 128'h8000_0000_0000_0000_0000_0000_0000_0001; B = A; Cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check("bp first result", Sum, 128'h0000_0000_0000_0000_0000_0000_0000_0003);
    sum0 = Sum; cout0 = Cout; ovf0 = Ovf;
    na = 128'hDEAD_BEEF_0000_0001_FFFF_FFFF_0000_0000;
    nb = 128'h2152_4111_FFFF_FFFF_0000_0001_FFFF_FFFF;
    A = na; B = nb; Cin = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("bp hold ctl %0d", i), W'({out_valid, in_ready, Cout, Ovf}),
            W'({1'b1, 1'b0, cout0, ovf0}));
      check($sformatf("bp hold sum %0d", i), Sum, sum0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp release valid/ready", W'({out_valid, in_ready}), W'(2'b01));
    tick();
    in_valid = 1'b0;
    check("bp accepted", W'(in_ready), '0);
    lat = 0;
    while (!out_valid && lat < 50) begin tick(); lat++; end
    check("bp latency", W'(lat), W'(W / N));
    e = model_big(na, nb, 1'b1);
    check("bp new sum", Sum, e.sum);
    check("bp new cout/ovf", W'({Cout, Ovf}), W'({e.cout, e.ovf}));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset during the second RUN cycle.
    A = 128'hFFFF_0000_1111_2222_3333_4444_5555_1234; B = W'(1); Cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("midreset sum", Sum, '0);
    check("midreset cout/ovf", W'({Cout, Ovf}), '0);
    check("midreset valid/ready", W'({out_valid, in_ready}), W'(2'b01));
    @(negedge clk);
    reset = 1'b0;
    tick();
    run_op("after reset", W'(5), W'(7), 1'b1, W'(13), 1'b0, 1'b0);

    // Randomized traffic on both configurations.
    acc_b = 0; acc_s = 0; done_b = 0; done_s = 0; cyc = 0;
    while ((done_b < NRAND || done_s < NRAND) && cyc < 80000) begin
      out_ready = (($urandom % 10) < 6);
      if (out_valid && out_ready) begin
        if (qb.size() == 0) begin
          check("rand big unexpected result", W'(1), '0);
        end else begin
          e = qb.pop_front();
          check("rand big sum", Sum, e.sum);
          check("rand big cout/ovf", W'({Cout, Ovf}), W'({e.cout, e.ovf}));
          done_b++;
        end
      end
      A = rand_op(); B = rand_op(); Cin = 1'($urandom);
      in_valid = (($urandom % 4) != 0) && (acc_b < NRAND);
      if (in_valid && in_ready) begin
        qb.push_back(model_big(A, B, Cin));
        acc_b++;
      end

      s_out_ready = (($urandom % 10) < 6);
      if (s_out_valid && s_out_ready) begin
        if (qs.size() == 0) begin
          check("rand small unexpected result", W'(1), '0);
        end else begin
          e = qs.pop_front();
          check("rand small sum", W'(s_Sum), e.sum);
          check("rand small cout/ovf", W'({s_Cout, s_Ovf}), W'({e.cout, e.ovf}));
          done_s++;
        end
      end
      sa = rand_op_s(); sb = rand_op_s(); sc = 1'($urandom);
      s_A = sa; s_B = sb; s_Cin = sc;
      s_in_valid = (($urandom % 4) != 0) && (acc_s < NRAND);
      if (s_in_valid && s_in_ready) begin
        qs.push_back(model_small(sa, sb, sc));
        acc_s++;
      end

      tick();
      cyc++;
    end
    in_valid = 1'b0; s_in_valid = 1'b0;
    check("rand big completed", W'(done_b), W'(NRAND));
    check("rand small completed", W'(done_s), W'(NRAND));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
